decoder_for_out: RTL and testbench
==================================

# decoder_for_out

One-based binary-to-one-hot output decoder. Converts an index `in` into a one-hot select vector of width OUT_SIZE: index k (1..OUT_SIZE) asserts bit k-1, and index 0 or any index above OUT_SIZE asserts nothing. It drives per-output enables (e.g. selecting one of 34 output pins/routes) in the fabric output path. It provides a combinational decode and a registered copy for timing-critical consumers.

## Interface
Parameters:
- IN_SIZE, 6, width of index input.
- OUT_SIZE, 34, number of one-hot outputs; must satisfy 1 <= OUT_SIZE <= 2**IN_SIZE - 1.

Ports:
- clk  input  1  system clock; one clock domain.
- nrst  input  1  reset, asynchronous, active-low.
- in  input  IN_SIZE  one-based output index; 0 means "none".
- out  output  OUT_SIZE  combinational one-hot decode of `in`.
- out_q  output  OUT_SIZE  `out` registered on rising clk.
- valid  output  1  combinational; 1 when 1 <= in <= OUT_SIZE.
- valid_q  output  1  `valid` registered on rising clk.

## Operation
- Combinational decode: `out[j] = (in == j+1)` for j = 0..OUT_SIZE-1.
- in = 0: out = all zeros, valid = 0.
- 1 <= in <= OUT_SIZE: exactly one bit set, bit index in-1; valid = 1.
- in > OUT_SIZE (e.g. 35..63 at defaults): out = all zeros, valid = 0; no wrap-around, no saturation, no modulo.
- Comparison is unsigned, at full IN_SIZE width; no truncation of `in`.
- `out` never has more than one bit set (popcount(out) == valid).
- Registered path: each rising clk, out_q <= out, valid_q <= valid.
- X/Z on `in` is not required to be handled; behaviour is defined only for known values.

## Timing
- `out`, `valid`: purely combinational, zero cycle latency; settle within the same cycle `in` changes, without a clock edge (must work with clk idle).
- `out_q`, `valid_q`: one cycle latency; reflect `in` sampled at the previous rising clk.
- Reset: nrst low asynchronously forces out_q = 0 and valid_q = 0 immediately, independent of clk; held while nrst low.
- Reset does not affect the combinational outputs; `out`/`valid` track `in` even during reset.
- Reset release: first rising clk with nrst high captures the current decode.
- Reset asserted mid-operation: registered outputs clear at once; no partial/one-hot glitch retained.
- No handshake; `in` may change every cycle.

## Structure
- Package `decoder_for_out_pkg`: default constants DEC_IN_SIZE = 6, DEC_OUT_SIZE = 34; no typedefs required.
- Sub-module `onehot_dec` (parameters IN_SIZE, OUT_SIZE): combinational core producing `out` and `valid`; `decoder_for_out` instantiates it and adds the output register bank with async active-low reset.
- Elaboration-time check: error if OUT_SIZE < 1 or OUT_SIZE > 2**IN_SIZE - 1.

## Test plan
- Sweep with clk idle: in = 1..34 one at a time, 10 ns apart -> out = 34'b1 << (in-1), valid = 1 each step (in=1 -> 34'h1, in=34 -> bit 33 only).
- Lower bound: in = 0 -> out = 34'b0, valid = 0.
- Out of range: in = 35, 40, 63 -> out = 34'b0, valid = 0.
- Registered path: nrst high, in = 5 then rising clk -> out_q = 34'h10, valid_q = 1; in = 40 then rising clk -> out_q = 0, valid_q = 0.
- Async reset: with out_q = 34'h10, drop nrst between clk edges -> out_q = 0, valid_q = 0 immediately while `out` still shows decode of `in`; release nrst, next rising clk restores out_q.
- One-hot invariant: random `in` over 0..63 for 1000 cycles -> popcount(out) == valid and out_q equals previous-cycle `out`.

Source files
------------

// File: rtl/decoder_for_out_pkg.sv
// Purpose  : shared defaults and a size-legality helper for the output-select decoder.
// Latency  : n/a (constants and a constant function only).
// Backpress: n/a.
// Ports    : none.
package decoder_for_out_pkg;

  // Default geometry: a 6-bit one-based index selecting one of 34 output routes.
  localparam int DEC_IN_SIZE  = 6;
  localparam int DEC_OUT_SIZE = 34;

  // True when out_size outputs can each be given a distinct non-zero index
  // in an in_size-bit field. Index 0 is reserved for "none", so the largest
  // usable count is 2**in_size - 1. Evaluated at elaboration time.
  function automatic bit dec_size_ok(input int in_size, input int out_size);
    longint max_idx;
    max_idx = (longint'(1) << in_size) - 1;
    return (out_size >= 1) && (longint'(out_size) <= max_idx);
  endfunction

endpackage

// File: rtl/decoder_for_out_onehot_dec.sv
// Purpose  : combinational one-based index to one-hot decode core.
// Latency  : zero cycles; purely combinational, no clock needed.
// Backpress: none; the input may change every cycle.
// Ports    : in    - one-based index, 0 = none
//            out   - one-hot select, bit (in-1) set when in is in range
//            valid - 1 when 1 <= in <= OUT_SIZE
module onehot_dec
  import decoder_for_out_pkg::*;
#(
  parameter int IN_SIZE  = DEC_IN_SIZE,
  parameter int OUT_SIZE = DEC_OUT_SIZE
) (
  input  logic [IN_SIZE-1:0]  in,
  output logic [OUT_SIZE-1:0] out,
  output logic                valid
);

  // Each output bit is an independent full-width equality compare, so an
  // out-of-range index can never alias onto a low bit through truncation.
  always_comb begin
    out = '0;
    for (int j = 0; j < OUT_SIZE; j++) begin
      out[j] = (in == IN_SIZE'(j + 1));
    end
  end

  // Range check kept separate from the one-hot vector so valid does not sit
  // behind a wide OR-reduce of the decode.
  always_comb begin
    valid = (in != '0) && (in <= IN_SIZE'(OUT_SIZE));
  end

endmodule

// File: rtl/decoder_for_out.sv
// Purpose  : output-path select decoder; one-hot enables plus a registered copy.
// Latency  : out/valid zero cycles; out_q/valid_q one cycle after the sampling edge.
// Backpress: none; no handshake, the index may change every cycle.
// Ports    : clk     - system clock
//            nrst    - asynchronous active-low reset (clears registered outputs only)
//            in      - one-based index, 0 = none
//            out     - combinational one-hot decode of in
//            valid   - combinational, 1 when 1 <= in <= OUT_SIZE
//            out_q   - out registered on rising clk
//            valid_q - valid registered on rising clk
module decoder_for_out
  import decoder_for_out_pkg::*;
#(
  parameter int IN_SIZE  = DEC_IN_SIZE,
  parameter int OUT_SIZE = DEC_OUT_SIZE
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [IN_SIZE-1:0]  in,
  output logic [OUT_SIZE-1:0] out,
  output logic [OUT_SIZE-1:0] out_q,
  output logic                valid,
  output logic                valid_q
);

  // Reject geometries where some output could not be addressed by a
  // distinct non-zero index.
  if (!dec_size_ok(IN_SIZE, OUT_SIZE)) begin : g_bad_size
    $error("decoder_for_out: OUT_SIZE=%0d must be in 1..2**IN_SIZE-1 (IN_SIZE=%0d)",
           OUT_SIZE, IN_SIZE);
  end

  logic [OUT_SIZE-1:0] w_out;
  logic                w_valid;
  logic [OUT_SIZE-1:0] r_out_q;
  logic                r_valid_q;

  onehot_dec #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE)
  ) u_onehot_dec (
    .in    (in),
    .out   (w_out),
    .valid (w_valid)
  );

  // Reset reaches only the register bank; the combinational decode keeps
  // tracking the index while nrst is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_q   <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_out_q   <= w_out;
      r_valid_q <= w_valid;
    end
  end

  assign out     = w_out;
  assign valid   = w_valid;
  assign out_q   = r_out_q;
  assign valid_q = r_valid_q;

endmodule

// File: tb/tb_decoder_for_out.sv
// Purpose  : scoreboard bench for decoder_for_out against a behavioural index model.
// Latency  : checks combinational outputs in-cycle and registered outputs one edge later.
// Backpress: n/a; the bench drives a new index whenever it likes.
module tb_decoder_for_out;

  localparam int IN_W  = 6;
  localparam int OUT_N = 34;

  logic              clk;
  logic              nrst;
  logic [IN_W-1:0]   in;
  logic [OUT_N-1:0]  out;
  logic [OUT_N-1:0]  out_q;
  logic              valid;
  logic              valid_q;

  bit clk_en;

  decoder_for_out #(
    .IN_SIZE  (IN_W),
    .OUT_SIZE (OUT_N)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .in      (in),
    .out     (out),
    .out_q   (out_q),
    .valid   (valid),
    .valid_q (valid_q)
  );

  // Clock only toggles while enabled, so the sweep can run with clk idle.
  initial begin
    clk = 1'b0;
    forever #5 clk = clk_en ? ~clk : 1'b0;
  end

  // Reference model: index k in 1..OUT_N selects output k-1, anything else selects nothing.
  function automatic logic [OUT_N-1:0] ref_out(input int idx);
    logic [OUT_N-1:0] r;
    r = '0;
    if (idx >= 1 && idx <= OUT_N) r[idx-1] = 1'b1;
    return r;
  endfunction

  function automatic logic ref_valid(input int idx);
    return (idx >= 1 && idx <= OUT_N);
  endfunction

  typedef struct {
    string            name;
    bit               is_reg;
    logic [OUT_N-1:0] exp_out;
    logic             exp_v;
  } exp_t;

  exp_t sb_q[$];
  event ev_chk;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected responses are queued by the stimulus side.
  task automatic expect_comb(input string name, input int idx);
    exp_t e;
    e.name = name; e.is_reg = 1'b0; e.exp_out = ref_out(idx); e.exp_v = ref_valid(idx);
    sb_q.push_back(e);
  endtask

  task automatic expect_reg(input string name, input int idx, input bit in_reset);
    exp_t e;
    e.name = name; e.is_reg = 1'b1;
    e.exp_out = in_reset ? '0 : ref_out(idx);
    e.exp_v   = in_reset ? 1'b0 : ref_valid(idx);
    sb_q.push_back(e);
  endtask

  // Hand the queued expectations to the monitor and hold inputs stable while it samples.
  task automatic fire();
    -> ev_chk;
    #1;
  endtask

  // Monitor: drains the scoreboard whenever the stimulus side presents a sample point.
  initial begin
    exp_t             e;
    logic [OUT_N-1:0] act_o;
    logic             act_v;
    forever begin
      @(ev_chk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.is_reg) begin
          act_o = out_q; act_v = valid_q;
        end else begin
          act_o = out;   act_v = valid;
        end
        n_cmp++;
        if (act_o !== e.exp_out || act_v !== e.exp_v) begin
          n_bad++;
          $display("FAIL %s: got out=%h valid=%b, expected out=%h valid=%b (in=%0d t=%0t)",
                   e.name, act_o, act_v, e.exp_out, e.exp_v, in, $time);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion before t=200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev;
    int v;
    clk_en = 1'b0;
    nrst   = 1'b0;
    in     = '0;

    // Reset state with clk idle.
    #10;
    expect_reg ("reset_reg", 0, 1'b1);
    expect_comb("reset_comb_in0", 0);
    fire();

    // Sweep 1..OUT_N with clk idle: combinational path settles without edges,
    // registered path stays cleared.
    nrst = 1'b1;
    for (int i = 1; i <= OUT_N; i++) begin
      in = IN_W'(i);
      #10;
      expect_comb($sformatf("sweep_in%0d", i), i);
      fire();
    end
    expect_reg("idle_clk_reg_hold", 0, 1'b1);
    fire();

    // Lower bound and out-of-range indices.
    begin
      int edge_vals[4] = '{0, 35, 40, 63};
      foreach (edge_vals[k]) begin
        in = IN_W'(edge_vals[k]);
        #10;
        expect_comb($sformatf("bound_in%0d", edge_vals[k]), edge_vals[k]);
        fire();
      end
    end

    // Registered path.
    clk_en = 1'b1;
    @(negedge clk); in = IN_W'(5);
    @(posedge clk); #1;
    expect_reg("reg_in5", 5, 1'b0);
    fire();
    @(negedge clk); in = IN_W'(40);
    @(posedge clk); #1;
    expect_reg("reg_in40", 40, 1'b0);
    fire();
    @(negedge clk); in = IN_W'(5);
    @(posedge clk); #1;
    expect_reg("reg_in5_again", 5, 1'b0);
    fire();

    // Async reset between edges: registered outputs clear at once, decode keeps tracking.
    nrst = 1'b0;
    #1;
    expect_reg ("async_rst_reg", 5, 1'b1);
    expect_comb("async_rst_comb_in5", 5);
    fire();
    in = IN_W'(7);
    #1;
    expect_reg ("rst_held_reg", 7, 1'b1);
    expect_comb("rst_held_comb_in7", 7);
    fire();
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    expect_reg("rst_release_reg_in7", 7, 1'b0);
    fire();

    // Random indices over the full input range for 1000 cycles.
    prev = 7;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      v  = int'($urandom_range(0, (1 << IN_W) - 1));
      in = IN_W'(v);
      #1;
      expect_comb("rand_comb", v);
      expect_reg ("rand_reg", prev, 1'b0);
      fire();
      prev = v;
    end

    #2;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d unchecked entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
